// File: rtl/gmem_port_arbiter.sv
// gmem_port_arbiter
// Round-robin arbiter that shares one AXI master port on global memory among
// N_REQ word-wide load/store requesters. Only one AXI transaction is in
// flight at a time. Each 32-bit request becomes a single-beat INCR burst, and
// the word is placed in its lane of the wide GMEM data bus.
//
// Optional feature macro: GMEM_ARB_WRITE_ACK_EN
//   defined   -> every store returns a response beat that carries bresp
//   undefined -> stores retire at the B handshake without a response beat

module gmem_port_arbiter #(
    parameter int N_REQ       = 2,
    parameter int ADDR_W      = 28,
    parameter int DATA_W      = 32,
    parameter int GMEM_DATA_W = 128
) (
    input  logic                      clk,
    input  logic                      rst,

    // requester side
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ-1:0]          req_we,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_wdata,
    output logic [N_REQ-1:0]          rsp_valid,
    input  logic [N_REQ-1:0]          rsp_ready,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_err,

    // AXI write address
    output logic [ADDR_W-1:0]         m_axi_awaddr,
    output logic [7:0]                m_axi_awlen,
    output logic [2:0]                m_axi_awsize,
    output logic [1:0]                m_axi_awburst,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    // AXI write data
    output logic [GMEM_DATA_W-1:0]    m_axi_wdata,
    output logic [GMEM_DATA_W/8-1:0]  m_axi_wstrb,
    output logic                      m_axi_wlast,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    // AXI write response
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    // AXI read address
    output logic [ADDR_W-1:0]         m_axi_araddr,
    output logic [7:0]                m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    // AXI read data
    input  logic [GMEM_DATA_W-1:0]    m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    localparam int LANES          = GMEM_DATA_W / DATA_W;
    localparam int LANE_W         = $clog2(LANES);
    localparam int LANE_SW        = (LANE_W > 0) ? LANE_W : 1;
    localparam int BYTES_PER_LANE = DATA_W / 8;
    localparam int STRB_W         = GMEM_DATA_W / 8;
    localparam int OFF_W          = $clog2(STRB_W);
    localparam int IDX_W          = $clog2(N_REQ);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4,
        RESP    = 3'd5
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;

    logic [IDX_W-1:0]    last_r;
    logic [IDX_W-1:0]    idx_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic                aw_done_r;
    logic                w_done_r;
    logic [1:0]          resp_r;
    logic [DATA_W-1:0]   rdata_r;

    logic                win_found_s;
    logic [IDX_W-1:0]    win_idx_s;
    logic                accept_s;
    logic [LANE_SW-1:0]  lane_s;
    logic [DATA_W-1:0]   rdata_lane_s;
    logic                unused_addr_s;

    // Lane of the wide bus addressed by the captured request; byte offset
    // inside the word is ignored.
    generate
        if (LANE_W > 0) begin : g_lane
            assign lane_s = addr_r[LANE_W+1:2];
        end else begin : g_lane_single
            assign lane_s = 1'b0;
        end
    endgenerate

    // The sub-word byte offset plays no role in a word-wide access.
    assign unused_addr_s = ^addr_r[1:0];

    assign rdata_lane_s = m_axi_rdata[lane_s*DATA_W +: DATA_W];

    // Round-robin search: the first valid requester found upward from last+1.
    always_comb begin
        int cand;
        win_found_s = 1'b0;
        win_idx_s   = '0;
        cand        = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(last_r) + k) % N_REQ;
            if (!win_found_s && req_valid[IDX_W'(cand)]) begin
                win_found_s = 1'b1;
                win_idx_s   = IDX_W'(cand);
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    assign accept_s = (state_r == IDLE) && win_found_s;

    // Grant is offered to the round-robin winner only, and only while idle.
    always_comb begin
        req_ready = '0;
        if (accept_s) begin
            req_ready[win_idx_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Next-state decode for the single-outstanding-transaction sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (req_we[win_idx_s]) begin
                        state_nxt_s = WR;
                    end else begin
                        state_nxt_s = RD_ADDR;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WR: begin
                // AW and W may complete in either order or together
                if ((aw_done_r || m_axi_awready) && (w_done_r || m_axi_wready)) begin
                    state_nxt_s = WR_RESP;
                end else begin
                    state_nxt_s = WR;
                end
            end
            WR_RESP: begin
                if (m_axi_bvalid) begin
`ifdef GMEM_ARB_WRITE_ACK_EN
                    state_nxt_s = RESP;
`else
                    state_nxt_s = IDLE;
`endif
                end else begin
                    state_nxt_s = WR_RESP;
                end
            end
            RD_ADDR: begin
                if (m_axi_arready) begin
                    state_nxt_s = RD_DATA;
                end else begin
                    state_nxt_s = RD_ADDR;
                end
            end
            RD_DATA: begin
                if (m_axi_rvalid) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = RD_DATA;
                end
            end
            RESP: begin
                if (rsp_ready[idx_r]) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Request capture and round-robin pointer update on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_r  <= IDX_W'(N_REQ - 1);
            idx_r   <= '0;
            addr_r  <= '0;
            wdata_r <= '0;
        end else if (accept_s) begin
            last_r  <= win_idx_s;
            idx_r   <= win_idx_s;
            addr_r  <= req_addr[win_idx_s*ADDR_W +: ADDR_W];
            wdata_r <= req_wdata[win_idx_s*DATA_W +: DATA_W];
        end
    end

    // Per-channel completion flags for the AW and W handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
        end else begin
            case (state_r)
                WR: begin
                    if (m_axi_awready) begin
                        aw_done_r <= 1'b1;
                    end
                    if (m_axi_wready) begin
                        w_done_r <= 1'b1;
                    end
                end
                default: begin
                    aw_done_r <= 1'b0;
                    w_done_r  <= 1'b0;
                end
            endcase
        end
    end

    // Response capture: load word and resp code, cleared at each new accept
    // so that a write ack carries zero data.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_r  <= 2'b00;
            rdata_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        resp_r  <= 2'b00;
                        rdata_r <= '0;
                    end
                end
                WR_RESP: begin
                    if (m_axi_bvalid) begin
                        resp_r <= m_axi_bresp;
                    end
                end
                RD_DATA: begin
                    if (m_axi_rvalid) begin
                        resp_r  <= m_axi_rresp;
                        rdata_r <= rdata_lane_s;
                    end
                end
                default: begin
                    resp_r  <= resp_r;
                    rdata_r <= rdata_r;
                end
            endcase
        end
    end

    // Write strobe covering only the addressed lane.
    always_comb begin
        m_axi_wstrb = '0;
        for (int l = 0; l < LANES; l++) begin
            if (lane_s == LANE_SW'(l)) begin
                m_axi_wstrb[l*BYTES_PER_LANE +: BYTES_PER_LANE] = {BYTES_PER_LANE{1'b1}};
            end else begin
                m_axi_wstrb[l*BYTES_PER_LANE +: BYTES_PER_LANE] = {BYTES_PER_LANE{1'b0}};
            end
        end
    end

    // Response beat goes to the requester that owns the transaction.
    always_comb begin
        rsp_valid = '0;
        if (state_r == RESP) begin
            rsp_valid[idx_r] = 1'b1;
        end else begin
            rsp_valid = '0;
        end
    end

    assign rsp_data = rdata_r;
    assign rsp_err  = (resp_r != 2'b00);

    // AXI channel controls decode from registered state only.
    assign m_axi_awvalid = (state_r == WR) && !aw_done_r;
    assign m_axi_wvalid  = (state_r == WR) && !w_done_r;
    assign m_axi_wlast   = m_axi_wvalid;
    assign m_axi_bready  = (state_r == WR_RESP);
    assign m_axi_arvalid = (state_r == RD_ADDR);
    assign m_axi_rready  = (state_r == RD_DATA);

    assign m_axi_awaddr  = {addr_r[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign m_axi_araddr  = {addr_r[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign m_axi_awlen   = 8'd0;
    assign m_axi_arlen   = 8'd0;
    assign m_axi_awsize  = 3'(OFF_W);
    assign m_axi_arsize  = 3'(OFF_W);
    assign m_axi_awburst = 2'b01;
    assign m_axi_arburst = 2'b01;
    assign m_axi_wdata   = {LANES{wdata_r}};

endmodule

// File: tb/tb_gmem_port_arbiter.sv
// tb_gmem_port_arbiter
// Directed bench for gmem_port_arbiter at default parameters (2 requesters,
// 28-bit address, 32-bit word, 128-bit GMEM). Expectations follow the
// GMEM_ARB_WRITE_ACK_EN macro when it is defined for the build.

module tb_gmem_port_arbiter;

`ifdef GMEM_ARB_WRITE_ACK_EN
    localparam bit ACK = 1'b1;
`else
    localparam bit ACK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req_valid, req_we, req_ready, rsp_valid, rsp_ready;
    logic [55:0]  req_addr;
    logic [63:0]  req_wdata;
    logic [31:0]  rsp_data;
    logic         rsp_err;
    logic [27:0]  m_axi_awaddr, m_axi_araddr;
    logic [7:0]   m_axi_awlen, m_axi_arlen;
    logic [2:0]   m_axi_awsize, m_axi_arsize;
    logic [1:0]   m_axi_awburst, m_axi_arburst;
    logic         m_axi_awvalid, m_axi_awready;
    logic [127:0] m_axi_wdata;
    logic [15:0]  m_axi_wstrb;
    logic         m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [1:0]   m_axi_bresp;
    logic         m_axi_bvalid, m_axi_bready;
    logic         m_axi_arvalid, m_axi_arready;
    logic [127:0] m_axi_rdata;
    logic [1:0]   m_axi_rresp;
    logic         m_axi_rvalid, m_axi_rready;

    int n_cmp  = 0;
    int n_fail = 0;

    gmem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_ready(req_ready),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         we;
        logic [1:0]   sel;        // one-hot requester
        logic [27:0]  addr;
        logic [31:0]  wdata;
        logic [127:0] rdata;
        logic [1:0]   resp;       // rresp for loads, bresp for stores
        logic [27:0]  exp_axaddr;
        logic [15:0]  exp_strb;
        logic [31:0]  exp_data;
        logic         exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic slave_idle();
        m_axi_awready = 1'b0; m_axi_wready = 1'b0;
        m_axi_bvalid  = 1'b0; m_axi_bresp  = 2'b00;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
        m_axi_rdata   = 128'd0; m_axi_rresp = 2'b00;
    endtask

    task automatic place_req(input logic [1:0] sel, input logic we,
                             input logic [27:0] addr, input logic [31:0] wd);
        req_valid = sel;
        req_we    = we ? sel : 2'b00;
        req_addr  = sel[1] ? {addr, 28'd0} : {28'd0, addr};
        req_wdata = sel[1] ? {wd, 32'd0}   : {32'd0, wd};
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 2'b00; req_we = 2'b00; req_addr = 56'd0; req_wdata = 64'd0;
        rsp_ready = 2'b11;
        slave_idle();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One transaction against a zero-wait slave, checked cycle by cycle.
    task automatic run_vec(input vec_t v);
        logic [1:0] exp_rv;
        @(negedge clk);
        place_req(v.sel, v.we, v.addr, v.wdata);
        m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_arready = 1'b1;
        m_axi_bvalid  = 1'b1; m_axi_bresp  = v.resp;
        m_axi_rvalid  = 1'b1; m_axi_rresp  = v.resp; m_axi_rdata = v.rdata;
        #1 chk("vec_req_ready", 128'(req_ready), 128'(v.sel));
        @(negedge clk);                                    // cycle 1
        req_valid = 2'b00;
        if (v.we) begin
            chk("vec_awvalid", 128'(m_axi_awvalid), 128'(1'b1));
            chk("vec_wvalid",  128'(m_axi_wvalid),  128'(1'b1));
            chk("vec_wlast",   128'(m_axi_wlast),   128'(1'b1));
            chk("vec_awaddr",  128'(m_axi_awaddr),  128'(v.exp_axaddr));
            chk("vec_wstrb",   128'(m_axi_wstrb),   128'(v.exp_strb));
            chk("vec_wdata",   m_axi_wdata, {v.wdata, v.wdata, v.wdata, v.wdata});
        end else begin
            chk("vec_arvalid", 128'(m_axi_arvalid), 128'(1'b1));
            chk("vec_araddr",  128'(m_axi_araddr),  128'(v.exp_axaddr));
        end
        @(negedge clk);                                    // cycle 2
        if (v.we) begin
            chk("vec_bready",     128'(m_axi_bready),  128'(1'b1));
            chk("vec_aw_dropped", 128'(m_axi_awvalid), 128'(1'b0));
            chk("vec_w_dropped",  128'(m_axi_wvalid),  128'(1'b0));
        end else begin
            chk("vec_rready",     128'(m_axi_rready),  128'(1'b1));
            chk("vec_ar_dropped", 128'(m_axi_arvalid), 128'(1'b0));
        end
        @(negedge clk);                                    // cycle 3
        exp_rv = (!v.we || ACK) ? v.sel : 2'b00;
        chk("vec_rsp_valid", 128'(rsp_valid), 128'(exp_rv));
        if (exp_rv != 2'b00) begin
            chk("vec_rsp_data", 128'(rsp_data), 128'(v.exp_data));
            chk("vec_rsp_err",  128'(rsp_err),  128'(v.exp_err));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_acc;
        int last_cyc;

        vecs[0] = '{we:1'b0, sel:2'b01, addr:28'h0000108, wdata:32'h0,
                    rdata:{32'h33, 32'h22, 32'h11, 32'h00}, resp:2'b00,
                    exp_axaddr:28'h0000100, exp_strb:16'h0, exp_data:32'h22, exp_err:1'b0};
        vecs[1] = '{we:1'b0, sel:2'b10, addr:28'hFFFFFFC, wdata:32'h0,
                    rdata:{32'hA1A1A1A1, 32'hB2B2B2B2, 32'hC3C3C3C3, 32'hD4D4D4D4}, resp:2'b00,
                    exp_axaddr:28'hFFFFFF0, exp_strb:16'h0, exp_data:32'hA1A1A1A1, exp_err:1'b0};
        vecs[2] = '{we:1'b0, sel:2'b01, addr:28'h0000004, wdata:32'h0,
                    rdata:{32'h0, 32'h0, 32'h5555AAAA, 32'h0}, resp:2'b11,
                    exp_axaddr:28'h0000000, exp_strb:16'h0, exp_data:32'h5555AAAA, exp_err:1'b1};
        vecs[3] = '{we:1'b0, sel:2'b10, addr:28'h000010F, wdata:32'h0,
                    rdata:{32'h76543210, 32'h1, 32'h2, 32'h3}, resp:2'b00,
                    exp_axaddr:28'h0000100, exp_strb:16'h0, exp_data:32'h76543210, exp_err:1'b0};
        vecs[4] = '{we:1'b1, sel:2'b10, addr:28'h0000004, wdata:32'hDEADBEEF,
                    rdata:128'd0, resp:2'b00,
                    exp_axaddr:28'h0000000, exp_strb:16'h00F0, exp_data:32'h0, exp_err:1'b0};
        vecs[5] = '{we:1'b1, sel:2'b01, addr:28'h123456B, wdata:32'hCAFEF00D,
                    rdata:128'd0, resp:2'b10,
                    exp_axaddr:28'h1234560, exp_strb:16'h0F00, exp_data:32'h0, exp_err:1'b1};
        vecs[6] = '{we:1'b1, sel:2'b01, addr:28'h000000C, wdata:32'h12345678,
                    rdata:128'd0, resp:2'b00,
                    exp_axaddr:28'h0000000, exp_strb:16'hF000, exp_data:32'h0, exp_err:1'b0};

        // ---- reset state ----
        do_reset();
        @(negedge clk);
        chk("rst_req_ready", 128'(req_ready),     128'(2'b00));
        chk("rst_rsp_valid", 128'(rsp_valid),     128'(2'b00));
        chk("rst_rsp_data",  128'(rsp_data),      128'(32'd0));
        chk("rst_rsp_err",   128'(rsp_err),       128'(1'b0));
        chk("rst_awvalid",   128'(m_axi_awvalid), 128'(1'b0));
        chk("rst_wvalid",    128'(m_axi_wvalid),  128'(1'b0));
        chk("rst_arvalid",   128'(m_axi_arvalid), 128'(1'b0));
        chk("rst_bready",    128'(m_axi_bready),  128'(1'b0));
        chk("rst_rready",    128'(m_axi_rready),  128'(1'b0));
        chk("const_awlen",   128'(m_axi_awlen),   128'(8'd0));
        chk("const_arsize",  128'(m_axi_arsize),  128'(3'd4));
        chk("const_awburst", 128'(m_axi_awburst), 128'(2'b01));

        // ---- table-driven single transactions ----
        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i]);
        end
        @(negedge clk);
        slave_idle();

        // ---- write with wready two cycles after awready ----
        @(negedge clk);
        place_req(2'b10, 1'b1, 28'h0000004, 32'hDEADBEEF);
        #1 chk("dw_req_ready", 128'(req_ready), 128'(2'b10));
        @(negedge clk);                                    // cycle 1
        req_valid = 2'b00;
        chk("dw_awvalid_c1", 128'(m_axi_awvalid), 128'(1'b1));
        chk("dw_wvalid_c1",  128'(m_axi_wvalid),  128'(1'b1));
        m_axi_awready = 1'b1;
        @(negedge clk);                                    // cycle 2
        m_axi_awready = 1'b0;
        chk("dw_awvalid_c2", 128'(m_axi_awvalid), 128'(1'b0));
        chk("dw_wvalid_c2",  128'(m_axi_wvalid),  128'(1'b1));
        chk("dw_wstrb",      128'(m_axi_wstrb),   128'(16'h00F0));
        chk("dw_awaddr",     128'(m_axi_awaddr),  128'(28'h0));
        chk("dw_bready_c2",  128'(m_axi_bready),  128'(1'b0));
        @(negedge clk);                                    // cycle 3
        chk("dw_wvalid_c3",  128'(m_axi_wvalid),  128'(1'b1));
        m_axi_wready = 1'b1;
        @(negedge clk);                                    // cycle 4
        m_axi_wready = 1'b0;
        chk("dw_bready_c4",  128'(m_axi_bready),  128'(1'b1));
        chk("dw_wvalid_c4",  128'(m_axi_wvalid),  128'(1'b0));
        m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00;
        @(negedge clk);                                    // cycle 5
        m_axi_bvalid = 1'b0;
        chk("dw_rsp_valid",  128'(rsp_valid), 128'(ACK ? 2'b10 : 2'b00));
        chk("dw_rsp_data",   128'(rsp_data),  128'(32'd0));
        chk("dw_bready_c5",  128'(m_axi_bready), 128'(1'b0));
        @(negedge clk);
        chk("dw_rsp_done",   128'(rsp_valid), 128'(2'b00));

        // ---- both requesters continuously: grants alternate, 4 cycles apart ----
        do_reset();
        @(negedge clk);
        req_valid = 2'b11; req_we = 2'b00;
        req_addr  = {28'h0000020, 28'h0000010};
        m_axi_arready = 1'b1; m_axi_rvalid = 1'b1;
        m_axi_rdata   = {32'h4, 32'h3, 32'h2, 32'h1};
        n_acc = 0; last_cyc = 0;
        for (int c = 0; c < 40 && n_acc < 4; c++) begin
            #1;
            chk("rr_at_most_one", 128'($countones(req_ready) <= 1), 128'(1'b1));
            if (req_ready != 2'b00) begin
                chk("rr_grant", 128'(req_ready), 128'((n_acc % 2 == 0) ? 2'b01 : 2'b10));
                if (n_acc > 0) begin
                    chk("rr_spacing", 128'(c - last_cyc), 128'(4));
                end
                last_cyc = c;
                n_acc++;
            end
            @(negedge clk);
        end
        req_valid = 2'b00;
        chk("rr_accept_count", 128'(n_acc), 128'(4));
        repeat (4) @(negedge clk);
        slave_idle();

        // ---- read error and stalled response ----
        @(negedge clk);
        rsp_ready = 2'b00;
        place_req(2'b01, 1'b0, 28'h0000008, 32'h0);
        m_axi_arready = 1'b1; m_axi_rvalid = 1'b1; m_axi_rresp = 2'b10;
        m_axi_rdata   = {32'h0, 32'h0BADF00D, 32'h0, 32'h0};
        #1 chk("st_req_ready", 128'(req_ready), 128'(2'b01));
        @(negedge clk);                                    // cycle 1
        place_req(2'b10, 1'b0, 28'h0000040, 32'h0);
        #1 chk("st_no_grant_busy", 128'(req_ready), 128'(2'b00));
        @(negedge clk);                                    // cycle 2
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);                                // cycles 3..7
            #1;
            chk("st_rsp_valid", 128'(rsp_valid), 128'(2'b01));
            chk("st_rsp_data",  128'(rsp_data),  128'(32'h0BADF00D));
            chk("st_rsp_err",   128'(rsp_err),   128'(1'b1));
            chk("st_no_grant",  128'(req_ready), 128'(2'b00));
        end
        rsp_ready = 2'b11;
        @(negedge clk);
        #1;
        chk("st_rsp_released", 128'(rsp_valid), 128'(2'b00));
        chk("st_next_grant",   128'(req_ready), 128'(2'b10));
        req_valid = 2'b00;
        slave_idle();

        // ---- reset while waiting in RD_DATA ----
        @(negedge clk);
        place_req(2'b01, 1'b0, 28'h0000030, 32'h0);
        m_axi_arready = 1'b1;
        #1 chk("rd_rst_req_ready", 128'(req_ready), 128'(2'b01));
        @(negedge clk);                                    // cycle 1
        req_valid = 2'b00;
        @(negedge clk);                                    // cycle 2
        chk("rd_rst_rready", 128'(m_axi_rready), 128'(1'b1));
        rst = 1'b1;
        @(negedge clk);                                    // cycle 3
        chk("rd_rst_rready_low", 128'(m_axi_rready),  128'(1'b0));
        chk("rd_rst_arvalid",    128'(m_axi_arvalid), 128'(1'b0));
        chk("rd_rst_awvalid",    128'(m_axi_awvalid), 128'(1'b0));
        chk("rd_rst_wvalid",     128'(m_axi_wvalid),  128'(1'b0));
        chk("rd_rst_bready",     128'(m_axi_bready),  128'(1'b0));
        chk("rd_rst_rsp_valid",  128'(rsp_valid),     128'(2'b00));
        rst = 1'b0;
        req_valid = 2'b11;
        #1 chk("rd_rst_grant0", 128'(req_ready), 128'(2'b01));
        req_valid = 2'b00;
        slave_idle();
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
